// File: rtl/ram_sync.sv
// Synchronous single-port-per-direction RAM with registered read
// and a self-timed clear sweep that zeroes every word in DEPTH cycles.
module ram_sync #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] wadd,
  input  logic [WIDTH-1:0]  in,
  input  logic              rd,
  input  logic [ADDR_W-1:0] radd,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              valid,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_out;
  logic              r_valid;
  logic              w_last;
  logic              w_idle_req;

  assign w_last     = (r_ptr == {ADDR_W{1'b1}});
  assign w_idle_req = (r_state == S_IDLE) && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (clear)  w_next = S_SWEEP;
      S_SWEEP: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_SWEEP);
  end

  // Pointer wraps back to 0 on the final sweep write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (r_state == S_SWEEP) begin
      r_ptr <= r_ptr + ADDR_W'(1);
    end else begin
      r_ptr <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == S_SWEEP) begin
      r_mem[r_ptr] <= '0;
    end else if (w_idle_req && load) begin
      r_mem[wadd] <= in;
    end
  end

  // Reads sample the pre-edge array, so same-address writes read old data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (!w_idle_req) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else if (rd) begin
      r_out   <= r_mem[radd];
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

endmodule

// File: doc/ram_sync.md
RAM_SYNC -- requirements
Module: ram_sync

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits; legal range 1..32.
REQ-002 Parameter ADDR_W, default 3, address width; DEPTH = 2^ADDR_W words; legal range 1..8.
REQ-003 clk  input  1  single clock; all state changes on rising edge except reset.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 load  input  1  write request; in is written to word wadd.
REQ-006 wadd  input  ADDR_W  write address.
REQ-007 in  input  WIDTH  write data.
REQ-008 rd  input  1  read request for word radd.
REQ-009 radd  input  ADDR_W  read address.
REQ-010 clear  input  1  request to zero every word via the internal sweep sequencer.
REQ-011 out  output  WIDTH  registered read data.
REQ-012 valid  output  1  high for exactly one cycle when out carries data from an accepted read.
REQ-013 busy  output  1  high while a clear sweep runs; all requests are ignored while high.

Function
REQ-014 The sequencer SHALL have two states: IDLE and SWEEP, with an ADDR_W-bit sweep pointer.
REQ-015 In IDLE, if clear=1 at a rising edge, the sequencer SHALL enter SWEEP with pointer=0, busy=1, out=0 and valid=0; load and rd on that edge SHALL be ignored.
REQ-016 In SWEEP, each rising edge SHALL write zero to word[pointer] and increment the pointer.
REQ-017 On the edge that writes word DEPTH-1, the sequencer SHALL return to IDLE with busy=0; busy is therefore high for exactly DEPTH cycles.
REQ-018 In SWEEP, load, rd and clear SHALL be ignored: no memory write from in, valid=0, out holds 0.
REQ-019 In IDLE with clear=0, load=1 at a rising edge SHALL write in to word[wadd], visible to reads from the next edge.
REQ-020 In IDLE with clear=0, rd=1 at a rising edge SHALL load out with word[radd] and set valid=1; read latency is 1 cycle.
REQ-021 In IDLE with rd=0, valid SHALL be 0 after the edge and out SHALL hold its previous value.
REQ-022 If the same edge has load=1, rd=1 and wadd==radd, out SHALL receive the old word (read-before-write), and the new value SHALL be stored.
REQ-023 Back-to-back reads on consecutive edges SHALL each produce valid=1 with the corresponding data; no bubble.
REQ-024 Writes and reads to different addresses on the same edge SHALL be fully independent.

Reset
REQ-025 While reset=0, asynchronously: all DEPTH words=0, out=0, valid=0, busy=0, state=IDLE, pointer=0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep immediately; after release the block is in IDLE with every word 0.
REQ-027 The first rising edge after reset release SHALL be able to accept load, rd or clear normally.

Verification
REQ-028 Reset, then write 4'b1100 to addr 0 and 4'b1111 to addr 1, then read addr 0 and addr 1 on consecutive edges -> out=1100 then 1111, with valid=1 on both cycles.
REQ-029 Write 4'b0101 to addr 7, and on the next edge load=1 wadd=7 in=1010 with rd=1 radd=7 -> out=0101 and valid=1; a following read of addr 7 -> 1010.
REQ-030 Fill all 8 words with nonzero data, pulse clear for one cycle -> busy=1 for exactly 8 cycles; load and rd issued during busy are ignored (valid stays 0); afterwards reads of all 8 addresses return 0000.
REQ-031 Assert clear and load (wadd=2, in=1001) on the same IDLE edge -> after the sweep, word 2 reads 0000.
REQ-032 Drop reset at sweep cycle 3 -> busy=0 and out=0 immediately; after release, a read of any address returns 0000 and a new write/read works.
REQ-033 Repeat REQ-028 and REQ-030 with WIDTH=8 and ADDR_W=4 -> busy lasts 16 cycles, and full-width data (e.g. 8'hA5) round-trips intact.
